// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - icache/dcache refill arbiter onto a single valid/ready memory channel
module cache_mem_arbiter #(
    parameter int LINE_W     = 128,
    parameter int ADDR_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              ic_req_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic              ic_ack_o,
    output logic [LINE_W-1:0] ic_rdata_o,
    input  logic              dc_req_i,
    input  logic              dc_we_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_wdata_i,
    output logic              dc_ack_o,
    output logic [LINE_W-1:0] dc_rdata_o,
    output logic              mem_valid_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [LINE_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE,
        XFER,
        RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [LINE_W-1:0] wdata_q;
    logic [LINE_W-1:0] ic_rdata_q;
    logic [LINE_W-1:0] dc_rdata_q;
    logic [CNT_W-1:0]  starve_cnt;
    logic              grant_dc;
    logic              grant_ic;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // dcache wins unless the icache is waiting and its patience has run out
    always_comb begin
        state_nxt = state;
        grant_dc  = 1'b0;
        grant_ic  = 1'b0;
        case (state)
            IDLE: begin
                if (dc_req_i && (!ic_req_i || starve_cnt < STARVE_LIM)) begin
                    grant_dc  = 1'b1;
                    state_nxt = XFER;
                end else if (ic_req_i) begin
                    grant_ic  = 1'b1;
                    state_nxt = XFER;
                end
            end
            XFER: begin
                if (mem_ready_i) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner      <= 1'b0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
            starve_cnt <= '0;
        end else begin
            if (grant_dc || grant_ic) begin
                owner   <= grant_dc;
                addr_q  <= grant_dc ? dc_addr_i : ic_addr_i;
                we_q    <= grant_dc & dc_we_i;
                wdata_q <= grant_dc ? dc_wdata_i : '0;
            end

            if (state == XFER && mem_ready_i && !we_q) begin
                if (owner) begin
                    dc_rdata_q <= mem_rdata_i;
                end else begin
                    ic_rdata_q <= mem_rdata_i;
                end
            end

            if (state == IDLE) begin
                if (grant_ic || !ic_req_i) begin
                    starve_cnt <= '0;
                end else if (grant_dc && starve_cnt < STARVE_LIM) begin
                    starve_cnt <= starve_cnt + CNT_W'(1);
                end
            end
        end
    end

    // Decoded straight from state so an async reset drops the request at once
    assign mem_valid_o = (state == XFER);
    assign mem_we_o    = (state == XFER) & we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign ic_ack_o    = (state == RESP) & ~owner;
    assign dc_ack_o    = (state == RESP) & owner;
    assign ic_rdata_o  = ic_rdata_q;
    assign dc_rdata_o  = dc_rdata_q;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    logic         clk_i;
    logic         rst_ni;
    logic         ic_req_i;
    logic [31:0]  ic_addr_i;
    logic         ic_ack_o;
    logic [127:0] ic_rdata_o;
    logic         dc_req_i;
    logic         dc_we_i;
    logic [31:0]  dc_addr_i;
    logic [127:0] dc_wdata_i;
    logic         dc_ack_o;
    logic [127:0] dc_rdata_o;
    logic         mem_valid_o;
    logic         mem_we_o;
    logic [31:0]  mem_addr_o;
    logic [127:0] mem_wdata_o;
    logic         mem_ready_i;
    logic [127:0] mem_rdata_i;
    logic         busy_o;

    cache_mem_arbiter #(.LINE_W(128), .ADDR_W(32), .STARVE_MAX(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_ack_o(ic_ack_o), .ic_rdata_o(ic_rdata_o),
        .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i), .dc_wdata_i(dc_wdata_i),
        .dc_ack_o(dc_ack_o), .dc_rdata_o(dc_rdata_o),
        .mem_valid_o(mem_valid_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .busy_o(busy_o)
    );

    typedef struct {
        logic [31:0]  addr;
        logic         we;
        logic [127:0] wdata;
        logic [127:0] line;
    } mem_exp_t;

    typedef struct {
        logic         dc;
        logic [127:0] rdata;
    } ack_exp_t;

    typedef struct {
        logic         dc;
        logic         we;
        logic [31:0]  addr;
        logic [127:0] wdata;
        logic [127:0] line;
        int           waits;
    } vec_t;

    mem_exp_t     exp_mem[$];
    ack_exp_t     exp_ack[$];
    logic [127:0] exp_dc_last;
    int           mem_wait;
    int           errors;
    int           checks;

    localparam logic [127:0] LINE_DEAD = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic dc, input logic we, input logic [31:0] addr,
                            input logic [127:0] wdata, input logic [127:0] line);
        mem_exp_t m;
        ack_exp_t a;
        m.addr  = addr;
        m.we    = we;
        m.wdata = wdata;
        m.line  = line;
        exp_mem.push_back(m);
        a.dc = dc;
        if (dc && we) begin
            a.rdata = exp_dc_last;
        end else begin
            a.rdata = line;
            if (dc) exp_dc_last = line;
        end
        exp_ack.push_back(a);
    endtask

    // Memory model: ready after mem_wait stall cycles, returns the line of the expected request
    initial begin : responder
        int  wait_left;
        bit  seen;
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        seen        = 1'b0;
        wait_left   = 0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_valid_o) begin
                if (!seen) begin
                    seen      = 1'b1;
                    wait_left = mem_wait;
                end
                if (wait_left == 0) begin
                    mem_ready_i = 1'b1;
                    mem_rdata_i = (exp_mem.size() > 0) ? exp_mem[0].line : '0;
                end else begin
                    wait_left--;
                    mem_ready_i = 1'b0;
                end
            end else begin
                seen        = 1'b0;
                mem_ready_i = 1'b0;
            end
        end
    end

    initial begin : mem_monitor
        mem_exp_t f;
        forever begin
            @(negedge clk_i);
            if (mem_valid_o) begin
                if (exp_mem.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_mem_req actual=valid expected=idle");
                end else begin
                    f = exp_mem[0];
                    chk("mem_addr", mem_addr_o, f.addr);
                    chk("mem_we", mem_we_o, f.we);
                    if (f.we) chk("mem_wdata", mem_wdata_o, f.wdata);
                    if (mem_ready_i) void'(exp_mem.pop_front());
                end
            end
        end
    end

    initial begin : ack_monitor
        ack_exp_t e;
        forever begin
            @(negedge clk_i);
            if (ic_ack_o || dc_ack_o) begin
                chk("ack_with_valid", mem_valid_o, 1'b0);
                chk("double_ack", ic_ack_o & dc_ack_o, 1'b0);
                if (exp_ack.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack actual=ic%0b_dc%0b expected=none", ic_ack_o, dc_ack_o);
                end else begin
                    e = exp_ack.pop_front();
                    chk("ack_owner", dc_ack_o, e.dc);
                    chk("ack_rdata", e.dc ? dc_rdata_o : ic_rdata_o, e.rdata);
                end
            end
        end
    end

    task automatic do_req(input logic dc, input logic we, input logic [31:0] addr,
                          input logic [127:0] wdata, output int nvalid);
        bit got;
        got    = 1'b0;
        nvalid = 0;
        if (dc) begin
            dc_req_i = 1'b1; dc_we_i = we; dc_addr_i = addr; dc_wdata_i = wdata;
        end else begin
            ic_req_i = 1'b1; ic_addr_i = addr;
        end
        for (int c = 0; c < 300; c++) begin
            @(negedge clk_i);
            if (mem_valid_o) nvalid++;
            if (dc ? dc_ack_o : ic_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        chk(dc ? "dc_ack_timeout" : "ic_ack_timeout", got, 1'b1);
        @(posedge clk_i);
        #1;
        if (dc) dc_req_i = 1'b0;
        else    ic_req_i = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    vec_t vecs[6];

    initial begin
        int nv;
        int ndc;
        bit got;
        errors      = 0;
        checks      = 0;
        mem_wait    = 0;
        exp_dc_last = '0;
        rst_ni      = 1'b0;
        ic_req_i    = 1'b0;
        ic_addr_i   = '0;
        dc_req_i    = 1'b0;
        dc_we_i     = 1'b0;
        dc_addr_i   = '0;
        dc_wdata_i  = '0;

        vecs[0] = '{dc: 1'b0, we: 1'b0, addr: 32'h0000_0040, wdata: '0, line: LINE_DEAD, waits: 0};
        vecs[1] = '{dc: 1'b1, we: 1'b1, addr: 32'h0000_0100, wdata: {8{16'h1111}}, line: {4{32'h5A5A_A5A5}}, waits: 3};
        vecs[2] = '{dc: 1'b1, we: 1'b0, addr: 32'h0000_0180, wdata: '0, line: {4{32'hCAFE_F00D}}, waits: 1};
        vecs[3] = '{dc: 1'b1, we: 1'b1, addr: 32'h0000_01C0, wdata: {4{32'h3333_CCCC}}, line: '0, waits: 0};
        vecs[4] = '{dc: 1'b0, we: 1'b0, addr: 32'h7FFF_FFC0, wdata: '0, line: '1, waits: 2};
        vecs[5] = '{dc: 1'b1, we: 1'b0, addr: 32'hFFFF_FFC0, wdata: '0, line: {2{64'h0123_4567_89AB_CDEF}}, waits: 0};

        repeat (3) @(negedge clk_i);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_valid", mem_valid_o, 1'b0);
        chk("rst_we", mem_we_o, 1'b0);
        chk("rst_addr", mem_addr_o, '0);
        chk("rst_wdata", mem_wdata_o, '0);
        chk("rst_acks", {ic_ack_o, dc_ack_o}, '0);
        chk("rst_rdata", ic_rdata_o | dc_rdata_o, '0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        idle_cycles(2);

        for (int i = 0; i < 6; i++) begin
            mem_wait = vecs[i].waits;
            push_exp(vecs[i].dc, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].line);
            do_req(vecs[i].dc, vecs[i].we, vecs[i].addr, vecs[i].wdata, nv);
            chk("valid_cycles", nv, vecs[i].waits + 1);
            idle_cycles(1);
        end

        // exact latency of a zero-wait icache read
        mem_wait = 0;
        push_exp(1'b0, 1'b0, 32'h0000_0040, '0, ~LINE_DEAD);
        ic_req_i  = 1'b1;
        ic_addr_i = 32'h0000_0040;
        @(negedge clk_i);
        chk("lat_pre_valid", mem_valid_o, 1'b0);
        @(negedge clk_i);
        chk("lat_valid", {mem_valid_o, mem_we_o, ic_ack_o}, 3'b100);
        @(negedge clk_i);
        chk("lat_ack", {ic_ack_o, dc_ack_o, mem_valid_o}, 3'b100);
        chk("lat_rdata", ic_rdata_o, ~LINE_DEAD);
        @(posedge clk_i);
        #1;
        ic_req_i = 1'b0;
        @(negedge clk_i);
        chk("lat_idle", busy_o, 1'b0);
        idle_cycles(1);

        // icache starved by a continuously requesting dcache
        mem_wait = 0;
        for (int i = 0; i < 4; i++) push_exp(1'b1, 1'b0, 32'h0000_0800, '0, {4{32'h1000_0000 + i}});
        push_exp(1'b0, 1'b0, 32'h0000_0900, '0, {4{32'h2222_0000}});
        push_exp(1'b1, 1'b0, 32'h0000_0800, '0, {4{32'h1000_0004}});
        fork
            begin
                dc_req_i = 1'b1; dc_we_i = 1'b0; dc_addr_i = 32'h0000_0800;
                ndc = 0;
                for (int c = 0; c < 400; c++) begin
                    @(negedge clk_i);
                    if (dc_ack_o) ndc++;
                    if (ndc == 5) break;
                end
                chk("starve_dc_acks", ndc, 5);
                @(posedge clk_i);
                #1;
                dc_req_i = 1'b0;
            end
            begin
                int nv2;
                do_req(1'b0, 1'b0, 32'h0000_0900, '0, nv2);
            end
        join
        idle_cycles(2);

        // simultaneous requests with a cleared starve counter: dcache first
        push_exp(1'b1, 1'b1, 32'h0000_0A00, {4{32'hABCD_0001}}, '0);
        push_exp(1'b0, 1'b0, 32'h0000_0B00, '0, {4{32'h7777_8888}});
        fork
            begin int n1; do_req(1'b1, 1'b1, 32'h0000_0A00, {4{32'hABCD_0001}}, n1); end
            begin int n2; do_req(1'b0, 1'b0, 32'h0000_0B00, '0, n2); end
        join
        idle_cycles(2);

        // requester address changes while its transfer is stalled
        mem_wait = 4;
        push_exp(1'b0, 1'b0, 32'h0000_0200, '0, {4{32'h0BAD_F00D}});
        fork
            begin int n3; do_req(1'b0, 1'b0, 32'h0000_0200, '0, n3); end
            begin
                @(negedge clk_i);
                @(negedge clk_i);
                ic_addr_i = 32'h0000_0300;
                repeat (2) @(negedge clk_i);
                chk("addr_hold", {mem_valid_o, mem_addr_o}, {1'b1, 32'h0000_0200});
            end
        join
        idle_cycles(2);

        // async reset in the middle of a stalled transfer
        mem_wait = 10;
        push_exp(1'b0, 1'b0, 32'h0000_0440, '0, {4{32'h4444_0000}});
        ic_req_i  = 1'b1;
        ic_addr_i = 32'h0000_0440;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (mem_valid_o) begin got = 1'b1; break; end
        end
        chk("rst_mid_reached_xfer", got, 1'b1);
        @(negedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("rst_mid_drop", {mem_valid_o, busy_o, ic_ack_o, dc_ack_o}, '0);
        ic_req_i = 1'b0;
        exp_mem.delete();
        exp_ack.delete();
        exp_dc_last = '0;
        repeat (2) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        chk("post_rst_ctrl", {busy_o, mem_valid_o, mem_we_o, ic_ack_o, dc_ack_o}, '0);
        chk("post_rst_addr", mem_addr_o, '0);
        chk("post_rst_rdata", {ic_rdata_o | dc_rdata_o}, '0);
        chk("queues_drained", exp_mem.size() + exp_ack.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
